adder_tree_seq_ctrl: RTL and testbench

ADDER_TREE_SEQ_CTRL -- requirements
Module: adder_tree_seq_ctrl

---
 rtl/adder_tree_seq_ctrl.sv | 71 +++++++
 tb/tb_adder_tree_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/adder_tree_seq_ctrl.sv
// adder_tree_seq_ctrl: accumulates a 4- or 8-operand batch through one shared adder
// and presents the sum with a valid/ready handshake; abort cancels a batch in flight.
module adder_tree_seq_ctrl #(
    parameter int ADDER_WIDTH  = 23,
    parameter int MAX_OPERANDS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cfg_level,
    input  logic                   i_abort,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [ADDER_WIDTH-1:0] i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [ADDER_WIDTH+2:0] o_out_sum,
    output logic                   o_out_level,
    output logic                   o_busy
);
    localparam int SW = ADDER_WIDTH + 3;
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
    state_t        r_state;
    logic [SW-1:0] r_acc;
    logic [3:0]    r_cnt;
    logic          r_level;
    logic [SW-1:0] w_ext;
    logic [SW-1:0] w_sum;
    logic          w_last;
    assign w_ext  = SW'(i_in_data);
    assign w_sum  = r_acc + w_ext;
    assign w_last = (r_cnt + 4'd1) == (r_level ? 4'(MAX_OPERANDS) : 4'(MAX_OPERANDS / 2));
    // Handshake outputs decode straight from the state register so reset clears them at once.
    assign o_in_ready  = r_state != OUTPUT;
    assign o_out_valid = r_state == OUTPUT;
    assign o_busy      = r_state != IDLE;
    assign o_out_sum   = r_acc;
    assign o_out_level = r_level;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_abort) begin
            if (r_state != IDLE) begin
                r_state <= IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_level <= i_cfg_level;
                    r_acc   <= w_ext;
                    r_cnt   <= 4'd1;
                    r_state <= ACCUM;
                end
                ACCUM: if (i_in_valid) begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) r_state <= OUTPUT;
                end
                OUTPUT: if (i_out_ready) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// tb_adder_tree_seq_ctrl: directed and randomized batches checked against an
// arithmetic batch-sum model, including abort and asynchronous reset cases.
module tb_adder_tree_seq_ctrl;
    localparam int AW = 23;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_level = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW+2:0] out_sum;
    logic          out_level;
    logic          busy;
    logic [AW-1:0] ops [8];
    int total = 0;
    int bad = 0;

    adder_tree_seq_ctrl #(.ADDER_WIDTH(AW), .MAX_OPERANDS(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_cfg_level(cfg_level), .i_abort(abort),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_sum(out_sum),
        .o_out_level(out_level), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(ops[i]);
        return 64'(s);
    endfunction

    // Offer operands ops[start..n-1]; cfg_level is only meaningful on operand 0.
    task automatic drive_ops(input int start, input int n, input bit lvl, input bit gaps, input bit toggle);
        for (int i = start; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid  = 1'b0;
                cfg_level = toggle ? 1'($urandom) : lvl;
            end
            @(negedge clk);
            chk("in_ready_accum", 64'(in_ready), 64'(1));
            in_valid  = 1'b1;
            in_data   = ops[i];
            cfg_level = (i == 0) ? lvl : (toggle ? ~lvl : lvl);
        end
    endtask

    task automatic expect_out(input int n, input bit lvl, input int stall);
        logic [63:0] exp = model_sum(n);
        @(negedge clk);
        in_valid = 1'b0;
        chk("out_valid", 64'(out_valid), 64'(1));
        chk("out_sum", 64'(out_sum), exp);
        chk("out_level", 64'(out_level), 64'(lvl));
        chk("busy_out", 64'(busy), 64'(1));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            cfg_level = 1'($urandom);
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_sum", 64'(out_sum), exp);
            chk("stall_level", 64'(out_level), 64'(lvl));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 64'(out_valid), 64'(0));
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(out_sum), 64'(0));
        chk("rst_level", 64'(out_level), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        // 8 operands 1..8 back to back
        for (int i = 0; i < 8; i++) ops[i] = AW'(i + 1);
        drive_ops(0, 8, 1'b1, 1'b0, 1'b0);
        expect_out(8, 1'b1, 0);
        // 4 maximal operands in 2-level mode
        for (int i = 0; i < 8; i++) ops[i] = '1;
        drive_ops(0, 4, 1'b0, 1'b0, 1'b0);
        expect_out(4, 1'b0, 0);
        chk("lvl0_bit25", 64'(out_sum[AW+2]), 64'(0));
        // 8 maximal operands with bubbles, cfg_level toggling and a 5-cycle stall
        drive_ops(0, 8, 1'b1, 1'b1, 1'b1);
        expect_out(8, 1'b1, 5);
        // randomized batches
        for (int k = 0; k < 8; k++) begin
            bit lvl = 1'($urandom);
            for (int i = 0; i < 8; i++) ops[i] = AW'($urandom);
            drive_ops(0, lvl ? 8 : 4, lvl, 1'($urandom), 1'b1);
            expect_out(lvl ? 8 : 4, lvl, $urandom_range(0, 3));
        end
        // abort in IDLE drops the offered operand
        @(negedge clk);
        in_valid = 1'b1; in_data = 23'd9; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'(0));
        chk("idle_abort_ready", 64'(in_ready), 64'(1));
        // abort together with the 5th operand of an 8-operand batch
        for (int i = 0; i < 8; i++) ops[i] = AW'(i + 10);
        drive_ops(0, 4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = ops[4]; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_sum", 64'(out_sum), 64'(0));
        chk("abort_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 8; i++) ops[i] = AW'(1);
        drive_ops(0, 4, 1'b0, 1'b0, 1'b0);
        expect_out(4, 1'b0, 0);
        // abort during OUTPUT wins over a simultaneous result transfer
        for (int i = 0; i < 8; i++) ops[i] = AW'($urandom);
        drive_ops(0, 4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; abort = 1'b1;
        chk("pre_abort_valid", 64'(out_valid), 64'(1));
        @(negedge clk);
        out_ready = 1'b0; abort = 1'b0;
        chk("out_abort_valid", 64'(out_valid), 64'(0));
        chk("out_abort_sum", 64'(out_sum), 64'(0));
        // asynchronous reset while a result is stalled
        for (int i = 0; i < 8; i++) ops[i] = AW'($urandom);
        drive_ops(0, 8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'(0));
        chk("async_sum", 64'(out_sum), 64'(0));
        chk("async_level", 64'(out_level), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 8; i++) ops[i] = AW'(2);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = ops[0]; cfg_level = 1'b0;
        drive_ops(1, 4, 1'b0, 1'b0, 1'b0);
        expect_out(4, 1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
